// File: rtl/io_pkg.sv
// Shared constants for the I/O UART transmitter: address map, STATUS layout, FSM encoding.
// IO_UART_PARITY_EN adds the PARITY state encoding.
package io_pkg;

    localparam logic [3:0] ADDR_TXDATA = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_SWITCH = 4'h8;
    localparam logic [3:0] ADDR_LED    = 4'hC;

    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_BUSY_BIT  = 2;
    localparam int STAT_COUNT_LSB = 3;
    localparam int STAT_OVF_BIT   = 6;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_START  = 3'd1;
    localparam state_t S_DATA   = 3'd2;
`ifdef IO_UART_PARITY_EN
    localparam state_t S_PARITY = 3'd3;
`endif
    localparam state_t S_STOP   = 3'd4;

endpackage

// File: rtl/io_tx_fifo.sv
// Synchronous transmit FIFO with combinational (fall-through) read data.
// A push while full is accepted only when a pop happens in the same cycle.
module io_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          wr_en, rd_en;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    // Pointers are AW bits wide, so they wrap modulo DEPTH by themselves.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped UART transmitter with switch/LED registers and a transmit FIFO.
// Define IO_UART_PARITY_EN for an even-parity bit (11-bit frame); default is 10-bit 8N1.
//
// state   | meaning
// IDLE    | line high; pops the next byte when the FIFO is non-empty
// START   | start bit (low) for CLKS_PER_BIT cycles
// DATA    | 8 data bits, LSB first
// PARITY  | even parity bit (IO_UART_PARITY_EN only)
// STOP    | stop bit (high) for CLKS_PER_BIT cycles
module io_uart_tx
    import io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] IOWriteData,
    input  logic [3:0]  IOAddr,
    input  logic        IOWriteEn,
    output logic [31:0] IOReadData,
    input  logic [15:0] Switches,
    output logic [15:0] LEDs,
    output logic        TxD
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    state_t          state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic [15:0]     leds_q, leds_d;
    logic            ovf_q, ovf_d;

    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]      fifo_dout;
    logic [AW:0]     fifo_count;
    logic [4:0]      count_ext;
    logic [2:0]      count_sat;
    logic [1:0]      word;
    logic            baud_done, busy;
    logic            unused_bits;

    assign word        = IOAddr[3:2];
    assign fifo_push   = IOWriteEn && (word == ADDR_TXDATA[3:2]);
    assign baud_done   = (baud_q == CW'(CLKS_PER_BIT - 1));
    assign busy        = (state_q != S_IDLE);
    assign unused_bits = ^{IOWriteData[31:16], IOAddr[1:0]};

    io_tx_fifo #(.DEPTH(FIFO_DEPTH), .DW(8)) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (IOWriteData[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d = '0;
`ifdef IO_UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef IO_UART_PARITY_EN
            S_PARITY: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // TxD is registered from the current state so the line never glitches.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_q[bit_q];
`ifdef IO_UART_PARITY_EN
            S_PARITY: tx_d = ^shift_q;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_comb begin
        leds_d = leds_q;
        ovf_d  = ovf_q;
        if (IOWriteEn && (word == ADDR_LED[3:2])) begin
            leds_d = IOWriteData[15:0];
        end
        if (IOWriteEn && (word == ADDR_STATUS[3:2])) begin
            ovf_d = 1'b0;
        end else if (fifo_push && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        count_ext  = 5'(fifo_count);
        count_sat  = (count_ext > 5'd7) ? 3'd7 : count_ext[2:0];
        IOReadData = '0;
        case (word)
            ADDR_STATUS[3:2]: begin
                IOReadData[STAT_FULL_BIT]                 = fifo_full;
                IOReadData[STAT_EMPTY_BIT]                = fifo_empty;
                IOReadData[STAT_BUSY_BIT]                 = busy;
                IOReadData[STAT_COUNT_LSB +: 3]           = count_sat;
                IOReadData[STAT_OVF_BIT]                  = ovf_q;
            end
            ADDR_SWITCH[3:2]: IOReadData = {16'b0, Switches};
            ADDR_LED[3:2]:    IOReadData = {16'b0, leds_q};
            default:          IOReadData = '0;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            leds_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            leds_q  <= leds_d;
            ovf_q   <= ovf_d;
        end
    end

    assign TxD  = tx_q;
    assign LEDs = leds_q;

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Honours IO_UART_PARITY_EN for the expected frame length.
module tb_io_uart_tx;

    localparam int CPB = 4;
`ifdef IO_UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] IOWriteData;
    logic [3:0]  IOAddr;
    logic        IOWriteEn;
    logic [31:0] IOReadData;
    logic [15:0] Switches;
    logic [15:0] LEDs;
    logic        TxD;

    int n_cmp = 0;
    int n_bad = 0;

    io_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .IOWriteData (IOWriteData),
        .IOAddr      (IOAddr),
        .IOWriteEn   (IOWriteEn),
        .IOReadData  (IOReadData),
        .Switches    (Switches),
        .LEDs        (LEDs),
        .TxD         (TxD)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [15:0] sw;
        logic [3:0]  raddr;
        logic [31:0] exp_rd;
        logic [15:0] exp_led;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic io_write(input logic [3:0] addr, input logic [31:0] data);
        @(negedge CLK);
        IOWriteEn   = 1'b1;
        IOAddr      = addr;
        IOWriteData = data;
        @(posedge CLK);
        #1;
        IOWriteEn = 1'b0;
        IOAddr    = 4'h4;
    endtask

    // Push one byte and follow the whole frame on TxD and BUSY, one sample per cycle.
    task automatic send_frame(input logic [7:0] d);
        logic [10:0] fr;
        logic        exp_tx, exp_busy;
        fr = '1;
        fr[0] = 1'b0;
        for (int i = 0; i < 8; i++) fr[1+i] = d[i];
`ifdef IO_UART_PARITY_EN
        fr[9] = ^d;
`endif
        io_write(4'h0, {24'h0, d});
        for (int k = 0; k <= NB*CPB + 1; k++) begin
            @(negedge CLK);
            exp_tx   = (k < 2 || k >= 2 + NB*CPB) ? 1'b1 : fr[(k-2)/CPB];
            exp_busy = (k >= 1 && k <= NB*CPB);
            chk($sformatf("txd_%02h_k%0d", d, k), {31'b0, TxD}, {31'b0, exp_tx});
            chk($sformatf("busy_%02h_k%0d", d, k), {31'b0, IOReadData[2]}, {31'b0, exp_busy});
        end
    endtask

    initial begin
        logic found;
        logic ok;
        logic [31:0] st;

        vecs[0] = '{1'b0, 4'h0, 32'h0,          16'h0000, 4'h4, 32'h0000_0002, 16'h0000};
        vecs[1] = '{1'b1, 4'hC, 32'h0000_ABCD,  16'h0000, 4'hC, 32'h0000_ABCD, 16'hABCD};
        vecs[2] = '{1'b0, 4'h0, 32'h0,          16'h1234, 4'h8, 32'h0000_1234, 16'hABCD};
        vecs[3] = '{1'b0, 4'h0, 32'h0,          16'h1234, 4'h0, 32'h0000_0000, 16'hABCD};
        vecs[4] = '{1'b1, 4'hF, 32'hFFFF_5A5A,  16'h1234, 4'hD, 32'h0000_5A5A, 16'h5A5A};
        vecs[5] = '{1'b1, 4'h8, 32'h0000_7777,  16'h1234, 4'hC, 32'h0000_5A5A, 16'h5A5A};
        vecs[6] = '{1'b0, 4'h0, 32'h0,          16'hBEEF, 4'hB, 32'h0000_BEEF, 16'h5A5A};

        RESET = 1'b1; IOWriteEn = 1'b0; IOAddr = 4'h4; IOWriteData = '0; Switches = '0;
        #12;
        chk("reset_txd", {31'b0, TxD}, 32'h1);
        chk("reset_leds", {16'b0, LEDs}, 32'h0);
        chk("reset_status", IOReadData, 32'h0000_0002);
        @(negedge CLK);
        RESET = 1'b0;

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].we) io_write(vecs[i].waddr, vecs[i].wdata);
            else begin
                @(posedge CLK);
                #1;
            end
            Switches = vecs[i].sw;
            IOAddr   = vecs[i].raddr;
            #1;
            chk($sformatf("vec%0d_rdata", i), IOReadData, vecs[i].exp_rd);
            chk($sformatf("vec%0d_leds", i), {16'b0, LEDs}, {16'b0, vecs[i].exp_led});
        end
        IOAddr = 4'h4;

        send_frame(8'h55);
        send_frame(8'h07);

        // Five back-to-back pushes: one is popped at once, four remain.
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            IOWriteEn   = 1'b1;
            IOAddr      = 4'h0;
            IOWriteData = 32'hA0 + i;
        end
        @(posedge CLK);
        #1;
        IOWriteEn = 1'b0;
        IOAddr    = 4'h4;
        #1;
        chk("burst_full_status", IOReadData, 32'h0000_0025);
        io_write(4'h0, 32'hF6);
        #1;
        chk("overflow_status", IOReadData, 32'h0000_0065);
        io_write(4'h4, 32'h0);
        #1;
        chk("ovf_clear_status", IOReadData, 32'h0000_0025);

        // Push in the one IDLE cycle where the FSM pops from a full FIFO.
        found = 1'b0;
        st    = '0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge CLK);
            if (IOReadData[2] == 1'b0) begin
                found       = 1'b1;
                st          = IOReadData;
                IOWriteEn   = 1'b1;
                IOAddr      = 4'h0;
                IOWriteData = 32'hC3;
            end
        end
        chk("idle_gap_found", {31'b0, found}, 32'h1);
        chk("idle_gap_status", st, 32'h0000_0021);
        @(posedge CLK);
        #1;
        IOWriteEn = 1'b0;
        IOAddr    = 4'h4;
        #1;
        chk("push_pop_full_status", IOReadData, 32'h0000_0025);

        found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(negedge CLK);
            if (IOReadData == 32'h0000_0002) found = 1'b1;
        end
        chk("drain_done", {31'b0, found}, 32'h1);

        // Reset in the middle of data bit 3.
        io_write(4'h0, 32'h55);
        repeat (2 + 4*CPB + 1) @(negedge CLK);
        chk("pre_reset_bit3", {31'b0, TxD}, 32'h0);
        #2;
        RESET = 1'b1;
        #1;
        chk("midframe_reset_txd", {31'b0, TxD}, 32'h1);
        chk("midframe_reset_status", IOReadData, 32'h0000_0002);
        chk("midframe_reset_leds", {16'b0, LEDs}, 32'h0);
        @(negedge CLK);
        RESET = 1'b0;
        ok = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge CLK);
            if (TxD !== 1'b1 || IOReadData !== 32'h0000_0002) ok = 1'b0;
        end
        chk("no_resume_after_reset", {31'b0, ok}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
